addsub_slice_sequencer: RTL and testbench
=========================================

# addsub_slice_sequencer

Multi-cycle controller that computes a wide two's-complement add or subtract by sequencing a narrow SLICE-bit adder-subtractor datapath over SLICES operand slices, LSB slice first. The carry is registered between slices. The block sits in the Execute stage beside the ALU. It lets vector/scalar operations wider than the native adder width reuse one small adder instead of a full-width carry chain. Handshake is ready/start in, single-cycle done pulse out, with result and flags held until the next accepted operation.

## Interface
- SLICE, 8, width of the narrow adder-subtractor datapath in bits (≥2)
- SLICES, 4, number of slices per operation (≥1); operand width W = SLICE*SLICES
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request; accepted only on a rising edge where ready=1
- op_sub  in  1  0 = A+B, 1 = A−B; sampled with start
- a  in  W  operand A; sampled with start
- b  in  W  operand B; sampled with start
- ready  out  1  high in IDLE and not in reset
- done  out  1  one-cycle pulse, result/flags valid
- result  out  W  registered sum/difference, held until next acceptance
- flags  out  4  {N, Z, C, V}, registered, held like result

## Operation
- States: IDLE, CALC, DONE. Slice index idx counts 0..SLICES−1 (width clog2(SLICES), min 1).
- IDLE: ready=1. On start=1, latch a, b, op_sub. Clear carry register to op_sub. Clear the zero accumulator to 1. idx←0. Go to CALC. result/flags keep their old values until the first CALC write.
- CALC, each cycle, slice i=idx:
  - sa = A[i*SLICE +: SLICE], sb = B slice XOR {SLICE{op_sub}}.
  - {cy, s} = sa + sb + carry_reg (SLICE+1 bits). Write s into result slice i. carry_reg←cy. zacc←zacc & (s==0).
  - If idx==SLICES−1: go to DONE. Otherwise idx←idx+1.
- Final-slice flag capture, written on the transition to DONE:
  - N = result MSB.
  - Z = zacc including the last slice.
  - C = final cy. For subtract, C=1 means no borrow.
  - V = ~(a[W−1] ^ b[W−1] ^ op_sub) & (a[W−1] ^ s[SLICE−1]), using the latched operands.
- DONE: done=1 for exactly one cycle, ready=0, then unconditionally to IDLE.
- start while ready=0 is ignored. It is not queued and the latched operands do not change.
- SLICES=1: CALC lasts one cycle. Behaviour is otherwise identical.
- Reset (any state, including mid-CALC): state←IDLE, idx←0, carry←0, result←0, flags←0, done←0. The aborted operation produces no done.

## Timing
- Reset values: ready=0 while rst=1, then 1 on the first cycle after rst deasserts. done=0, result=0, flags=0.
- Acceptance at edge E0 (start=1, ready=1).
- Slice i is written at edge E(i+1).
- done is high during the cycle following edge E(SLICES); latency from acceptance is SLICES+1 cycles.
- ready returns high after edge E(SLICES+1). Throughput is one operation per SLICES+2 cycles.
- result slices below idx may update visibly during CALC. Consumers must only sample result on done.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.

## Configuration
- ADDSUB_SEQ_FLAGS_EN defined:
  - Flag logic, the zero accumulator and the V/N/C capture are present.
  - flags behaves as in Operation.
- ADDSUB_SEQ_FLAGS_EN undefined:
  - Flag logic and the zero accumulator are removed.
  - flags is tied to 4'b0000.
  - result, done, ready and timing are unchanged.

## Test plan
All scenarios use SLICE=8 and SLICES=4 (W=32).
- Add 0x0000_00FF + 0x0000_0001 → result 0x0000_0100, flags N0 Z0 C0 V0. done exactly 5 cycles after acceptance, ready back after 6. Checks the inter-slice carry.
- Sub 0x0000_0005 − 0x0000_0005 → 0x0000_0000, Z1 C1 N0 V0.
- Add 0x7FFF_FFFF + 0x0000_0001 → 0x8000_0000, N1 V1 C0 Z0. Sub 0x8000_0000 − 0x0000_0001 → 0x7FFF_FFFF, V1 N0 C1.
- Sub 0x0000_0000 − 0x0000_0001 → 0xFFFF_FFFF, N1 C0 V0 Z0. Add 0xFFFF_FFFF + 0x0000_0001 → 0, Z1 C1 V0.
- Hold start=1 with changing a/b during CALC → the in-flight result is unaffected and exactly one done appears. Assert rst at the 2nd CALC cycle → no done, result=0, flags=0, ready=1 on the cycle after rst deasserts.
- Rebuild without ADDSUB_SEQ_FLAGS_EN and rerun scenario 3 → result 0x8000_0000, flags=0000, identical done timing.

Source files
------------

// File: rtl/addsub_slice_sequencer.sv
// rtl/addsub_slice_sequencer.sv - wide add/subtract sequenced over a narrow SLICE-bit adder
//
// Purpose: computes A+B or A-B (W = SLICE*SLICES bits, two's complement) by
// running one SLICE-bit adder over the operand slices, LSB slice first, with
// the carry registered between slices. Handshake is ready/start in and a
// one-cycle done pulse out; result and flags hold until the next acceptance.
//
// Optional feature macro: ADDSUB_SEQ_FLAGS_EN
//   defined   : NZCV flag capture and the zero accumulator are built
//   undefined : o_flags is tied to 4'b0000, everything else is identical
//
// Ports:
//   i_clk      clock, rising edge
//   i_rst      synchronous active-high reset
//   i_start    request, accepted on an edge where o_ready=1
//   i_op_sub   0 = A+B, 1 = A-B, sampled with i_start
//   i_a, i_b   W-bit operands, sampled with i_start
//   o_ready    high while idle and out of reset
//   o_done     one-cycle pulse, o_result/o_flags valid
//   o_result   W-bit sum/difference, held until next acceptance
//   o_flags    {N, Z, C, V}, held like o_result

module addsub_slice_sequencer #(
  parameter int SLICE  = 8,
  parameter int SLICES = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  input  logic                      i_op_sub,
  input  logic [SLICE*SLICES-1:0]   i_a,
  input  logic [SLICE*SLICES-1:0]   i_b,
  output logic                      o_ready,
  output logic                      o_done,
  output logic [SLICE*SLICES-1:0]   o_result,
  output logic [3:0]                o_flags
);

  localparam int W  = SLICE * SLICES;
  localparam int IW = (SLICES > 1) ? $clog2(SLICES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [IW-1:0]      r_idx;
  logic               r_carry;
  logic               r_sub;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic [W-1:0]       r_result;
  logic               r_ready;
  logic               r_done;

  logic [SLICE-1:0]   w_sa;
  logic [SLICE-1:0]   w_sb;
  logic [SLICE:0]     w_sum;
  logic               w_last;
  logic               w_slice_zero;

  // Slice mux: pick operand slice idx; B is inverted for subtract and the
  // initial carry of op_sub supplies the +1 of the two's complement.
  always_comb begin
    w_sa = '0;
    w_sb = '0;
    for (int k = 0; k < SLICES; k++) begin
      if (r_idx == IW'(k)) begin
        w_sa = r_a[k*SLICE +: SLICE];
        w_sb = r_b[k*SLICE +: SLICE] ^ {SLICE{r_sub}};
      end
    end
  end

  assign w_sum        = {1'b0, w_sa} + {1'b0, w_sb} + {{SLICE{1'b0}}, r_carry};
  assign w_last       = (r_idx == IW'(SLICES - 1));
  assign w_slice_zero = (w_sum[SLICE-1:0] == '0);

`ifdef ADDSUB_SEQ_FLAGS_EN
  logic               r_zacc;
  logic [3:0]         r_flags;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_sub    <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_ready  <= 1'b0;
      r_done   <= 1'b0;
`ifdef ADDSUB_SEQ_FLAGS_EN
      r_zacc   <= 1'b0;
      r_flags  <= 4'b0000;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          // r_ready gates acceptance so the first idle cycle after reset
          // (ready still low) cannot take a request.
          if (i_start && r_ready) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_sub   <= i_op_sub;
            r_carry <= i_op_sub;
            r_idx   <= '0;
            r_ready <= 1'b0;
`ifdef ADDSUB_SEQ_FLAGS_EN
            r_zacc  <= 1'b1;
`endif
            r_state <= S_CALC;
          end else begin
            r_ready <= 1'b1;
          end
        end

        S_CALC: begin
          for (int k = 0; k < SLICES; k++) begin
            if (r_idx == IW'(k)) begin
              r_result[k*SLICE +: SLICE] <= w_sum[SLICE-1:0];
            end
          end
          r_carry <= w_sum[SLICE];
`ifdef ADDSUB_SEQ_FLAGS_EN
          r_zacc  <= r_zacc & w_slice_zero;
`endif
          if (w_last) begin
            r_idx   <= '0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
`ifdef ADDSUB_SEQ_FLAGS_EN
            // V: operands (after B inversion) share a sign that the result lacks.
            r_flags <= {w_sum[SLICE-1],
                        r_zacc & w_slice_zero,
                        w_sum[SLICE],
                        ~(r_a[W-1] ^ r_b[W-1] ^ r_sub) & (r_a[W-1] ^ w_sum[SLICE-1])};
`endif
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_ready  = r_ready;
  assign o_done   = r_done;
  assign o_result = r_result;

`ifdef ADDSUB_SEQ_FLAGS_EN
  assign o_flags  = r_flags;
`else
  assign o_flags  = 4'b0000;
`endif

endmodule

// File: tb/tb_addsub_slice_sequencer.sv
// tb/tb_addsub_slice_sequencer.sv - directed self-checking bench for addsub_slice_sequencer

module tb_addsub_slice_sequencer;

  logic        i_clk;
  logic        i_rst;
  logic        i_start;
  logic        i_op_sub;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic        o_ready;
  logic        o_done;
  logic [31:0] o_result;
  logic [3:0]  o_flags;

  int checks;
  int failures;
  int cyc;

  addsub_slice_sequencer #(.SLICE(8), .SLICES(4)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_start  (i_start),
    .i_op_sub (i_op_sub),
    .i_a      (i_a),
    .i_b      (i_b),
    .o_ready  (o_ready),
    .o_done   (o_done),
    .o_result (o_result),
    .o_flags  (o_flags)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Flags are only present when the feature macro is defined.
  function automatic logic [3:0] exp_fl(input logic [3:0] f);
`ifdef ADDSUB_SEQ_FLAGS_EN
    return f;
`else
    return 4'b0000;
`endif
  endfunction

  // Drives one operation from a negedge; returns at the negedge after done.
  task automatic run_op(input logic sub, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res, output logic [3:0] fl,
                        output logic rdy_after, output logic done_after, output int acc_cyc);
    int guard;
    guard = 0;
    while (!o_ready && guard < 20) begin
      @(negedge i_clk);
      guard++;
    end
    i_start  = 1'b1;
    i_op_sub = sub;
    i_a      = a;
    i_b      = b;
    @(posedge i_clk);
    acc_cyc = cyc;
    @(negedge i_clk);
    i_start = 1'b0;
    i_a     = '0;
    i_b     = '0;
    lat     = 1;
    while (!o_done && lat < 20) begin
      @(negedge i_clk);
      lat++;
    end
    res = o_result;
    fl  = o_flags;
    @(negedge i_clk);
    rdy_after  = o_ready;
    done_after = o_done;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_start = 1'b0; i_op_sub = 1'b0; i_a = '0; i_b = '0;
    repeat (3) @(negedge i_clk);
    checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", o_ready); end
    checks++; if (o_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", o_done); end
    checks++; if (o_result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=00000000", o_result); end
    checks++; if (o_flags !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", o_flags); end
    i_rst = 1'b0;
    @(negedge i_clk);
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b exp=1", o_ready); end
  endtask

  task automatic test_add_carry();
    int lat, acc; logic [31:0] res; logic [3:0] fl; logic rdy, dn;
    run_op(1'b0, 32'h0000_00FF, 32'h0000_0001, lat, res, fl, rdy, dn, acc);
    checks++; if (lat !== 5) begin failures++; $display("FAIL carry_latency got=%0d exp=5", lat); end
    checks++; if (res !== 32'h0000_0100) begin failures++; $display("FAIL carry_result got=%h exp=00000100", res); end
    checks++; if (fl !== exp_fl(4'b0000)) begin failures++; $display("FAIL carry_flags got=%b exp=%b", fl, exp_fl(4'b0000)); end
    checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL carry_ready_back got=%b exp=1", rdy); end
    checks++; if (dn !== 1'b0) begin failures++; $display("FAIL carry_done_pulse got=%b exp=0", dn); end
  endtask

  task automatic test_sub_zero();
    int lat, acc; logic [31:0] res; logic [3:0] fl; logic rdy, dn;
    run_op(1'b1, 32'h0000_0005, 32'h0000_0005, lat, res, fl, rdy, dn, acc);
    checks++; if (lat !== 5) begin failures++; $display("FAIL subz_latency got=%0d exp=5", lat); end
    checks++; if (res !== 32'h0) begin failures++; $display("FAIL subz_result got=%h exp=00000000", res); end
    checks++; if (fl !== exp_fl(4'b0110)) begin failures++; $display("FAIL subz_flags got=%b exp=%b", fl, exp_fl(4'b0110)); end
  endtask

  task automatic test_overflow();
    int lat, acc; logic [31:0] res; logic [3:0] fl; logic rdy, dn;
    run_op(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, lat, res, fl, rdy, dn, acc);
    checks++; if (lat !== 5) begin failures++; $display("FAIL ovf_add_latency got=%0d exp=5", lat); end
    checks++; if (res !== 32'h8000_0000) begin failures++; $display("FAIL ovf_add_result got=%h exp=80000000", res); end
    checks++; if (fl !== exp_fl(4'b1001)) begin failures++; $display("FAIL ovf_add_flags got=%b exp=%b", fl, exp_fl(4'b1001)); end
    checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL ovf_add_ready_back got=%b exp=1", rdy); end
    run_op(1'b1, 32'h8000_0000, 32'h0000_0001, lat, res, fl, rdy, dn, acc);
    checks++; if (res !== 32'h7FFF_FFFF) begin failures++; $display("FAIL ovf_sub_result got=%h exp=7fffffff", res); end
    checks++; if (fl !== exp_fl(4'b0011)) begin failures++; $display("FAIL ovf_sub_flags got=%b exp=%b", fl, exp_fl(4'b0011)); end
  endtask

  task automatic test_borrow_wrap();
    int lat, acc; logic [31:0] res; logic [3:0] fl; logic rdy, dn;
    run_op(1'b1, 32'h0000_0000, 32'h0000_0001, lat, res, fl, rdy, dn, acc);
    checks++; if (res !== 32'hFFFF_FFFF) begin failures++; $display("FAIL borrow_result got=%h exp=ffffffff", res); end
    checks++; if (fl !== exp_fl(4'b1000)) begin failures++; $display("FAIL borrow_flags got=%b exp=%b", fl, exp_fl(4'b1000)); end
    run_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, lat, res, fl, rdy, dn, acc);
    checks++; if (res !== 32'h0) begin failures++; $display("FAIL wrap_result got=%h exp=00000000", res); end
    checks++; if (fl !== exp_fl(4'b0110)) begin failures++; $display("FAIL wrap_flags got=%b exp=%b", fl, exp_fl(4'b0110)); end
  endtask

  task automatic test_start_held();
    int ndone, done_at; logic [31:0] res; logic [3:0] fl;
    ndone = 0; done_at = 0; res = '0; fl = '0;
    i_start = 1'b1; i_op_sub = 1'b0; i_a = 32'h7FFF_FFFF; i_b = 32'h0000_0001;
    @(posedge i_clk);
    for (int k = 1; k <= 12; k++) begin
      @(negedge i_clk);
      if (o_done) begin
        ndone++;
        if (ndone == 1) begin done_at = k; res = o_result; fl = o_flags; end
        i_start = 1'b0;
      end else if (i_start) begin
        i_a = $urandom; i_b = $urandom; i_op_sub = ~i_op_sub;
      end
    end
    checks++; if (ndone !== 1) begin failures++; $display("FAIL held_done_count got=%0d exp=1", ndone); end
    checks++; if (done_at !== 5) begin failures++; $display("FAIL held_latency got=%0d exp=5", done_at); end
    checks++; if (res !== 32'h8000_0000) begin failures++; $display("FAIL held_result got=%h exp=80000000", res); end
    checks++; if (fl !== exp_fl(4'b1001)) begin failures++; $display("FAIL held_flags got=%b exp=%b", fl, exp_fl(4'b1001)); end
    i_a = '0; i_b = '0; i_op_sub = 1'b0;
  endtask

  task automatic test_reset_mid_calc();
    int ndone;
    ndone = 0;
    i_start = 1'b1; i_op_sub = 1'b0; i_a = 32'h1111_1111; i_b = 32'h1111_1111;
    @(posedge i_clk);
    @(negedge i_clk);
    i_start = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    checks++; if (o_result[7:0] !== 8'h22) begin failures++; $display("FAIL abort_slice0_written got=%h exp=22", o_result[7:0]); end
    i_rst = 1'b1;
    @(negedge i_clk);
    checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL abort_ready_in_rst got=%b exp=0", o_ready); end
    checks++; if (o_result !== 32'h0) begin failures++; $display("FAIL abort_result got=%h exp=00000000", o_result); end
    checks++; if (o_flags !== 4'b0) begin failures++; $display("FAIL abort_flags got=%b exp=0000", o_flags); end
    i_rst = 1'b0;
    @(negedge i_clk);
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL abort_ready_after got=%b exp=1", o_ready); end
    for (int k = 0; k < 8; k++) begin
      if (o_done) ndone++;
      @(negedge i_clk);
    end
    checks++; if (ndone !== 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", ndone); end
    checks++; if (o_result !== 32'h0) begin failures++; $display("FAIL abort_result_stays got=%h exp=00000000", o_result); end
  endtask

  task automatic test_back_to_back();
    int lat, acc1, acc2; logic [31:0] res; logic [3:0] fl; logic rdy, dn;
    run_op(1'b0, 32'h1234_5678, 32'h0FED_CBA9, lat, res, fl, rdy, dn, acc1);
    checks++; if (res !== 32'h2222_2221) begin failures++; $display("FAIL b2b_first_result got=%h exp=22222221", res); end
    run_op(1'b1, 32'h0000_1000, 32'h0000_0001, lat, res, fl, rdy, dn, acc2);
    checks++; if (res !== 32'h0000_0FFF) begin failures++; $display("FAIL b2b_second_result got=%h exp=00000fff", res); end
    checks++; if (fl !== exp_fl(4'b0010)) begin failures++; $display("FAIL b2b_second_flags got=%b exp=%b", fl, exp_fl(4'b0010)); end
    checks++; if ((acc2 - acc1) !== 6) begin failures++; $display("FAIL b2b_throughput got=%0d exp=6", acc2 - acc1); end
    repeat (4) @(negedge i_clk);
    checks++; if (o_result !== 32'h0000_0FFF) begin failures++; $display("FAIL b2b_result_held got=%h exp=00000fff", o_result); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_add_carry();
    test_sub_zero();
    test_overflow();
    test_borrow_wrap();
    test_start_held();
    test_reset_mid_calc();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
